// File: rtl/code_entry_ctrl.sv
// code_entry_ctrl: keypad sequencer in front of the arm/disarm state machine.
// Collects CODE_LEN button presses, compares them digit-by-digit against CODE,
// and presents a verdict on o_input_states. The verdict is held for HOLD_CYCLES
// and then returns to idle. An attempt left idle for TIMEOUT_CYCLES between
// presses is closed as incorrect.
//
// Ports:
//   i_Clk            system clock
//   i_Reset          synchronous active-high reset
//   i_Btn[3:0]       debounced button levels, bit n = digit value n
//   o_input_states   0 idle, 1 entering, 2 incorrect, 3 correct
//   o_digit_count    digits accepted in the current attempt
//   o_busy           high while collecting or presenting a verdict
//   o_timeout        one-cycle pulse when an attempt is closed by timeout
module code_entry_ctrl #(
  parameter int unsigned              CODE_LEN       = 4,
  parameter logic [2*CODE_LEN-1:0]    CODE           = 8'b11_10_01_00,
  parameter int unsigned              TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned              HOLD_CYCLES    = 4
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Btn,
  output logic [1:0] o_input_states,
  output logic [2:0] o_digit_count,
  output logic       o_busy,
  output logic       o_timeout
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    LEN        = 3'(CODE_LEN);

  localparam logic [1:0] OUT_IDLE      = 2'd0;
  localparam logic [1:0] OUT_ENTERING  = 2'd1;
  localparam logic [1:0] OUT_INCORRECT = 2'd2;
  localparam logic [1:0] OUT_CORRECT   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESULT  = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    r_Btn;
  logic          mismatch;
  logic [TW-1:0] timer;
  logic [HW-1:0] hold;

  logic [1:0] code_digits [8];
  logic [3:0] press;
  logic       press_any;
  logic       press_single;
  logic [1:0] press_digit;
  logic [1:0] exp_digit;
  logic       digit_bad;
  logic       mismatch_next;
  logic [2:0] count_next;

  // Unpack CODE into per-position digits; unused positions read as zero.
  for (genvar k = 0; k < 8; k++) begin : g_digit
    if (k < CODE_LEN) begin : g_used
      assign code_digits[k] = CODE[2*k +: 2];
    end else begin : g_unused
      assign code_digits[k] = 2'b00;
    end
  end

  // Rising-edge detect and digit decode; multi-bit presses never match.
  always_comb begin
    press        = i_Btn & ~r_Btn;
    press_any    = |press;
    press_single = press_any && ((press & (press - 4'd1)) == 4'd0);
    press_digit  = 2'd0;
    case (press)
      4'b0010: press_digit = 2'd1;
      4'b0100: press_digit = 2'd2;
      4'b1000: press_digit = 2'd3;
      default: press_digit = 2'd0;
    endcase
    exp_digit     = code_digits[o_digit_count];
    digit_bad     = !press_single || (press_digit != exp_digit);
    mismatch_next = mismatch | digit_bad;
    count_next    = o_digit_count + 3'd1;
  end

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state          <= ST_IDLE;
      r_Btn          <= 4'b1111;
      mismatch       <= 1'b0;
      timer          <= '0;
      hold           <= '0;
      o_input_states <= OUT_IDLE;
      o_digit_count  <= 3'd0;
      o_busy         <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      r_Btn     <= i_Btn;
      o_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_input_states <= OUT_IDLE;
          o_digit_count  <= 3'd0;
          o_busy         <= 1'b0;
          mismatch       <= 1'b0;
          timer          <= '0;
          hold           <= '0;
          if (press_any) begin
            mismatch      <= digit_bad;
            o_digit_count <= 3'd1;
            o_busy        <= 1'b1;
            if (CODE_LEN == 1) begin
              state          <= ST_RESULT;
              o_input_states <= digit_bad ? OUT_INCORRECT : OUT_CORRECT;
            end else begin
              state          <= ST_COLLECT;
              o_input_states <= OUT_ENTERING;
            end
          end
        end

        ST_COLLECT: begin
          // A press on the timeout cycle wins over the timeout.
          if (press_any) begin
            mismatch      <= mismatch_next;
            o_digit_count <= count_next;
            timer         <= '0;
            if (count_next == LEN) begin
              state          <= ST_RESULT;
              hold           <= '0;
              o_input_states <= mismatch_next ? OUT_INCORRECT : OUT_CORRECT;
            end
          end else if (timer == TIMER_LAST) begin
            state          <= ST_RESULT;
            hold           <= '0;
            o_input_states <= OUT_INCORRECT;
            o_timeout      <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        ST_RESULT: begin
          // Presses are ignored while the verdict is held.
          if (hold == HOLD_LAST) begin
            state          <= ST_IDLE;
            hold           <= '0;
            timer          <= '0;
            mismatch       <= 1'b0;
            o_input_states <= OUT_IDLE;
            o_digit_count  <= 3'd0;
            o_busy         <= 1'b0;
          end else begin
            hold <= hold + HW'(1);
          end
        end

        default: begin
          state          <= ST_IDLE;
          mismatch       <= 1'b0;
          timer          <= '0;
          hold           <= '0;
          o_input_states <= OUT_IDLE;
          o_digit_count  <= 3'd0;
          o_busy         <= 1'b0;
          o_timeout      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: directed scenarios followed by randomized attempts.
// Expected outputs come from an attempt-level model: a press is correct only if
// it is exactly the one-hot of the code digit for its position, the verdict
// appears on the final press edge (or TIMEOUT edges after the last press), and
// it is held for HOLD edges before returning to idle.
module tb_code_entry_ctrl;

  localparam int unsigned CODE_LEN = 4;
  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned HOLD     = 4;
  localparam logic [7:0]  CODE     = 8'b11_10_01_00;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic [3:0] i_Btn;
  logic [1:0] o_input_states;
  logic [2:0] o_digit_count;
  logic       o_busy;
  logic       o_timeout;

  int tests = 0;
  int fails = 0;

  logic [3:0] att_mask [CODE_LEN];
  int         att_gap  [CODE_LEN];
  bit         att_hold [CODE_LEN];

  code_entry_ctrl #(
    .CODE_LEN      (CODE_LEN),
    .CODE          (CODE),
    .TIMEOUT_CYCLES(TIMEOUT),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .i_Clk         (i_Clk),
    .i_Reset       (i_Reset),
    .i_Btn         (i_Btn),
    .o_input_states(o_input_states),
    .o_digit_count (o_digit_count),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout)
  );

  always #5 i_Clk = ~i_Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int st, input int cnt,
                            input bit busy, input bit to);
    check({tag, "/states"},  8'(o_input_states), 8'(st));
    check({tag, "/count"},   8'(o_digit_count),  8'(cnt));
    check({tag, "/busy"},    8'(o_busy),         8'(busy));
    check({tag, "/timeout"}, 8'(o_timeout),      8'(to));
  endtask

  function automatic logic [3:0] good_mask(input int i);
    logic [7:0] c;
    c = CODE;
    return 4'b0001 << c[2*i +: 2];
  endfunction

  task automatic set_att(input logic [3:0] m0, input logic [3:0] m1,
                         input logic [3:0] m2, input logic [3:0] m3,
                         input int g0, input int g1, input int g2);
    att_mask[0] = m0; att_mask[1] = m1; att_mask[2] = m2; att_mask[3] = m3;
    att_gap[0]  = g0; att_gap[1]  = g1; att_gap[2]  = g2; att_gap[3]  = 3;
    for (int i = 0; i < CODE_LEN; i++) att_hold[i] = 1'b0;
  endtask

  // One full attempt (n == CODE_LEN) or an abandoned one (n < CODE_LEN).
  task automatic attempt(input string tag, input int n);
    bit bad;
    int verdict;
    bad = 1'b0;
    for (int i = 0; i < n; i++) bad |= (att_mask[i] != good_mask(i));
    verdict = bad ? 2 : 3;

    i_Btn = 4'd0;
    tick();
    expect_out({tag, " idle"}, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < n; i++) begin
      i_Btn = att_mask[i];
      tick();
      if (i == n - 1 && n == CODE_LEN) expect_out({tag, " final"}, verdict, n, 1'b1, 1'b0);
      else                             expect_out({tag, " press"}, 1, i + 1, 1'b1, 1'b0);
      if (i != n - 1) begin
        for (int g = 1; g < att_gap[i]; g++) begin
          i_Btn = (att_hold[i] && g < att_gap[i] - 1) ? att_mask[i] : 4'd0;
          tick();
          expect_out({tag, " gap"}, 1, i + 1, 1'b1, 1'b0);
        end
      end
    end

    if (n < CODE_LEN) begin
      verdict = 2;
      for (int j = 1; j <= int'(TIMEOUT); j++) begin
        i_Btn = att_hold[n-1] ? att_mask[n-1] : 4'd0;
        tick();
        if (j < int'(TIMEOUT)) expect_out({tag, " wait"}, 1, n, 1'b1, 1'b0);
        else                   expect_out({tag, " timeout"}, 2, n, 1'b1, 1'b1);
      end
    end

    // Random button activity during the hold window must be ignored.
    for (int j = 1; j <= int'(HOLD); j++) begin
      i_Btn = 4'($urandom_range(0, 15));
      tick();
      if (j < int'(HOLD)) expect_out({tag, " hold"}, verdict, n, 1'b1, 1'b0);
      else                expect_out({tag, " back_idle"}, 0, 0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int n;
    i_Reset = 1'b1;
    i_Btn   = 4'd0;
    tick();
    expect_out("reset", 0, 0, 1'b0, 1'b0);
    tick();
    i_Reset = 1'b0;

    set_att(4'b0001, 4'b0010, 4'b0100, 4'b1000, 3, 3, 3);
    attempt("correct", 4);

    set_att(4'b0001, 4'b0100, 4'b0100, 4'b1000, 3, 3, 3);
    attempt("wrong_digit", 4);

    set_att(4'b0001, 4'b0011, 4'b0100, 4'b1000, 3, 3, 3);
    attempt("simultaneous", 4);

    set_att(4'b0001, 4'b0010, 4'b0000, 4'b0000, 3, 3, 3);
    attempt("timeout", 2);

    // Third press lands exactly on the timeout edge.
    set_att(4'b0001, 4'b0010, 4'b0100, 4'b1000, 3, TIMEOUT, 3);
    attempt("press_on_timeout", 4);

    // Button 0 held for 10 cycles counts once.
    set_att(4'b0001, 4'b0010, 4'b0100, 4'b1000, 11, 3, 3);
    att_hold[0] = 1'b1;
    attempt("held_button", 4);

    // Reset after two digits discards the attempt.
    i_Btn = 4'd0; tick();
    i_Btn = 4'b0001; tick(); expect_out("pre_reset d1", 1, 1, 1'b1, 1'b0);
    i_Btn = 4'd0;    tick();
    i_Btn = 4'b0010; tick(); expect_out("pre_reset d2", 1, 2, 1'b1, 1'b0);
    i_Btn = 4'd0;
    i_Reset = 1'b1;
    tick();
    expect_out("mid_reset", 0, 0, 1'b0, 1'b0);
    i_Reset = 1'b0;
    for (int j = 0; j < int'(TIMEOUT + HOLD + 2); j++) begin
      tick();
      expect_out("after_reset", 0, 0, 1'b0, 1'b0);
    end

    // Button 1 held through reset is not a press until re-pressed.
    i_Btn = 4'b0010;
    i_Reset = 1'b1;
    tick();
    expect_out("held_reset", 0, 0, 1'b0, 1'b0);
    i_Reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      expect_out("held_through_reset", 0, 0, 1'b0, 1'b0);
    end
    set_att(4'b0010, 4'b0010, 4'b0100, 4'b1000, 3, 3, 3);
    attempt("repress", 4);

    // Back-to-back attempts: three wrong then correct.
    set_att(4'b1000, 4'b0010, 4'b0100, 4'b1000, 2, 2, 2);
    attempt("b2b_w1", 4);
    set_att(4'b0001, 4'b0010, 4'b0100, 4'b0100, 2, 2, 2);
    attempt("b2b_w2", 4);
    set_att(4'b0001, 4'b1111, 4'b0100, 4'b1000, 2, 2, 2);
    attempt("b2b_w3", 4);
    set_att(4'b0001, 4'b0010, 4'b0100, 4'b1000, 2, 2, 2);
    attempt("b2b_ok", 4);

    // Randomized attempts.
    for (int r = 0; r < 40; r++) begin
      n = ($urandom_range(0, 9) < 7) ? int'(CODE_LEN) : int'($urandom_range(1, CODE_LEN - 1));
      for (int i = 0; i < CODE_LEN; i++) begin
        att_mask[i] = ($urandom_range(0, 1) == 1) ? good_mask(i) : 4'($urandom_range(1, 15));
        att_gap[i]  = int'($urandom_range(2, TIMEOUT));
        att_hold[i] = ($urandom_range(0, 3) == 0);
      end
      attempt("rand", n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/code_entry_ctrl.md
# code_entry_ctrl

Keypad sequencer that sits in front of the security system's arm/disarm state machine. It collects button presses into a fixed-length code attempt, compares the attempt digit-by-digit against a parameterised code, and presents the verdict on the 2-bit `input_states` bus that drives the state machine. The verdict is held for a fixed window and then returned to idle, so that every attempt produces exactly one value change downstream. An attempt abandoned mid-entry times out and is reported as incorrect.

## Interface

**Clocking and reset.** One clock, `i_Clk`. Reset `i_Reset` is synchronous and active-high.

Parameters:
- `CODE_LEN`, default 4: number of digits per attempt, range 1–7.
- `CODE`, default 8'b11_10_01_00: expected digits, 2 bits each. Digit k is `CODE[2k+1:2k]` and is entered k-th, so the default sequence is 0,1,2,3. Width is 2*`CODE_LEN`.
- `TIMEOUT_CYCLES`, default 25_000_000: maximum idle cycles between presses while collecting. Must be ≥ 2.
- `HOLD_CYCLES`, default 4: number of cycles a verdict is held on `o_input_states`. Must be ≥ 1.

Ports (clock and reset first):
- `i_Clk`, input, 1: system clock.
- `i_Reset`, input, 1: synchronous active-high reset.
- `i_Btn`, input, 4: debounced button levels, one bit per digit value 0–3.
- `o_input_states`, output, 2: 0 = idle, 1 = entering, 2 = incorrect, 3 = correct.
- `o_digit_count`, output, 3: digits accepted in the current attempt.
- `o_busy`, output, 1: high in COLLECT or RESULT.
- `o_timeout`, output, 1: one-cycle pulse when an attempt is closed by timeout.

## Operation

**Press detection**
- `r_Btn` registers `i_Btn` every cycle.
- `press = i_Btn & ~r_Btn`.
- If `press` has exactly one bit set, it is a valid digit whose value is the index of that bit.
- If `press` has two or more bits set, it counts as one digit and is always a mismatch.
- `press == 0` is ignored.
- During reset, `r_Btn` is loaded with 4'b1111. A button held through reset does not register until it has been released and pressed again.

**States**
- **IDLE**
  - Outputs: `o_input_states = 0`, count = 0, `o_busy = 0`.
  - On any press: compare against digit 0, set `mismatch` accordingly, set count = 1, clear the timer, go to COLLECT.
  - If `CODE_LEN == 1`, go directly to RESULT instead.
- **COLLECT**
  - Outputs: `o_input_states = 1`.
  - Each press compares against digit[count], ORs the result into `mismatch`, increments count and clears the timer.
  - When the press makes count == `CODE_LEN`, go to RESULT with verdict 3 if `mismatch == 0`, otherwise verdict 2.
  - With no press, the timer increments. When the timer reaches `TIMEOUT_CYCLES-1`, go to RESULT with verdict 2 and pulse `o_timeout`.
  - A press in the same cycle as the timeout takes priority over the timeout.
- **RESULT**
  - Outputs: `o_input_states` = verdict; count holds its final value.
  - All presses are ignored.
  - The hold counter runs for `HOLD_CYCLES` cycles, then the block returns to IDLE.
- **Illegal state encodings** recover to IDLE with all outputs at their reset values.

**Reset values.** On reset, mid-operation or otherwise, the block enters IDLE on the next edge with:
- `o_input_states = 0`, `o_digit_count = 0`, `o_busy = 0`, `o_timeout = 0`
- `mismatch = 0`, all timers = 0

The attempt in progress is discarded and no verdict is emitted.

**Widths**
- Timer width is `$clog2(TIMEOUT_CYCLES)`.
- Hold counter width is `$clog2(HOLD_CYCLES+1)`.
- Neither counter may wrap. Both saturate by construction because the state changes at their terminal values.

## Timing

- All outputs are registered.
- A press sampled at edge k (`i_Btn` = 1 and `r_Btn` = 0 at k) updates state, count and `o_input_states` so they are visible after edge k.
- For the final digit, accepted at edge k:
  - The verdict is visible after edge k.
  - `o_input_states` returns to 0 after edge k+`HOLD_CYCLES`.
  - The next attempt's first press can be accepted at edge k+`HOLD_CYCLES`+1 or later.
- Timeout: with the last accepted press at edge p and no further press, the verdict 2 and the `o_timeout` pulse are visible after edge p+`TIMEOUT_CYCLES`. `o_timeout` is high for exactly one cycle.
- Downstream sequence per attempt: 0→1→{2|3}→0. The 1 is skipped when `CODE_LEN == 1`. Consecutive verdicts are always separated by 0, so the downstream FSM sees every attempt as a change.

## Test plan

Bench parameters: `CODE_LEN=4`, `CODE=8'b11_10_01_00`, `TIMEOUT_CYCLES=20`, `HOLD_CYCLES=4`.

- **Correct code.** Press buttons 0,1,2,3, one per 3 cycles. Required:
  - `o_input_states` is 1 after the first press, with `o_digit_count` stepping 1..4.
  - It reads 3 for exactly 4 cycles after the 4th press, then 0.
  - `o_busy` falls at the same edge `o_input_states` returns to 0.
- **Wrong digit and simultaneous press.**
  - Sequence 0,2,2,3 → verdict 2, held 4 cycles.
  - Separately, press 0, then 4'b0011 in a single cycle, then 2,3 → verdict 2.
- **Timeout.** Press 0,1, then idle. Required:
  - 20 cycles after the 2nd press, `o_input_states` = 2 and `o_timeout` is high for exactly one cycle.
  - A press arriving on the timeout cycle instead advances count to 3 and no timeout occurs.
- **Held button.** Hold button 0 for 10 cycles → only one digit is counted. Presses during RESULT are ignored, and count is still 0 after the return to IDLE.
- **Reset.**
  - Assert `i_Reset` for 1 cycle after 2 digits → all outputs are 0 on the next edge and no verdict is emitted.
  - Hold button 1 through reset and keep holding → no press is registered until release and re-press.
- **Back-to-back attempts.** Wrong, wrong, wrong, correct → `o_input_states` sequence 0,1,2,0,1,2,0,1,2,0,1,3,0, with no consecutive repeated nonzero verdict.
